// File: rtl/sram_like_to_axi.sv
// sram_like_to_axi: bridges the core's SRAM-like instruction and data ports
// onto a single AXI-style master. Only one single-beat transaction is in
// flight at a time. Fixed priority chooses between the two requesters.
module sram_like_to_axi #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_q, src_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bresp_q, bresp_d;

    logic        dataSel;
    logic        acceptEn;
    logic        awHs;
    logic        wHs;

    // The winning requester is chosen combinationally; the data side takes
    // the slot only when it has priority or the fetch side is quiet.
    assign dataSel  = data_req && (DATA_PRIORITY || !inst_req);

    // No acceptance while in reset or while the registered store completion
    // is being reported, so a new access always starts after data_ok.
    assign acceptEn = resetn && !bresp_q;

    // Latched request fields drive both AXI address channels directly.
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    // Byte strobes derived from the latched size and low address bits.
    always_comb begin
        wstrb = 4'b1111;
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

    // Next-state and output decode for the single-outstanding transaction FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        src_d        = src_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bresp_d      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = bresp_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        awHs         = 1'b0;
        wHs          = 1'b0;

        case (state_q)
            IDLE: begin
                if (acceptEn) begin
                    if (dataSel) begin
                        data_addr_ok = 1'b1;
                        src_d        = 1'b1;
                        addr_d       = data_addr;
                        size_d       = data_size;
                        wdata_d      = data_wdata;
                        aw_done_d    = 1'b0;
                        w_done_d     = 1'b0;
                        state_d      = data_wr ? AW_W : AR;
                    end else if (inst_req) begin
                        inst_addr_ok = 1'b1;
                        src_d        = 1'b0;
                        addr_d       = inst_addr;
                        size_d       = inst_size;
                        state_d      = AR;
                    end
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = R;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (src_q) begin
                        data_data_ok = 1'b1;
                    end else begin
                        inst_data_ok = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            AW_W: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                awHs      = awvalid && awready;
                wHs       = wvalid && wready;
                aw_done_d = aw_done_q || awHs;
                w_done_d  = w_done_q || wHs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = B;
                end
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    bresp_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            size_q    <= 2'd0;
            wdata_q   <= 32'd0;
            src_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bresp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            src_q     <= src_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Directed testbench for sram_like_to_axi: each scenario task drives the
// SRAM-like and AXI-slave inputs cycle by cycle and checks hand-derived values.
module tb_sram_like_to_axi;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int passCount;
    int checkCount;

    sram_like_to_axi #(.DATA_PRIORITY(1'b1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next cycle; inputs are driven right after the falling
    // edge and outputs are sampled 1ns later, well away from the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        step();
        step();
        #0;
        checkCount++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) $display("[TB] FAIL reset_addr_ok: got %b%b expected 00", inst_addr_ok, data_addr_ok); else passCount++;
        checkCount++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) $display("[TB] FAIL reset_valids: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready}); else passCount++;
        checkCount++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) $display("[TB] FAIL reset_data_ok: got %b%b expected 00", inst_data_ok, data_data_ok); else passCount++;
        checkCount++; if (araddr !== 32'h0 || wstrb !== 4'b0001 || wdata !== 32'h0) $display("[TB] FAIL reset_latched: got addr %h strb %b wdata %h expected 0/0001/0", araddr, wstrb, wdata); else passCount++;
        inst_req = 1'b0;
        data_req = 1'b0;
        resetn   = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00000;
        inst_size = 2'd2;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h3C1DBFC0;
        #1;
        checkCount++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) $display("[TB] FAIL fetch_addr_ok: got %b%b expected 10", inst_addr_ok, data_addr_ok); else passCount++;
        step();
        inst_req = 1'b0;
        #1;
        checkCount++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00000 || arsize !== 3'b010) $display("[TB] FAIL fetch_ar: got v%b %h sz%b expected v1 bfc00000 sz010", arvalid, araddr, arsize); else passCount++;
        checkCount++; if (inst_data_ok !== 1'b0) $display("[TB] FAIL fetch_early_ok: got %b expected 0", inst_data_ok); else passCount++;
        step();
        checkCount++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C1DBFC0 || data_data_ok !== 1'b0) $display("[TB] FAIL fetch_data: got ok%b %h dok%b expected ok1 3c1dbfc0 dok0", inst_data_ok, inst_rdata, data_data_ok); else passCount++;
        step();
        checkCount++; if (inst_data_ok !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) $display("[TB] FAIL fetch_idle: got ok%b arv%b rr%b expected 000", inst_data_ok, arvalid, rready); else passCount++;
        rvalid  = 1'b0;
        arready = 1'b0;
    endtask

    task automatic test_priority();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00004;
        inst_size = 2'd2;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h80001004;
        data_size = 2'd2;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h11112222;
        #1;
        checkCount++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) $display("[TB] FAIL prio_grant: got d%b i%b expected d1 i0", data_addr_ok, inst_addr_ok); else passCount++;
        step();
        data_req = 1'b0;
        #1;
        checkCount++; if (araddr !== 32'h80001004 || inst_addr_ok !== 1'b0) $display("[TB] FAIL prio_ar: got %h iok%b expected 80001004 iok0", araddr, inst_addr_ok); else passCount++;
        step();
        checkCount++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h11112222 || inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b0) $display("[TB] FAIL prio_data: got dok%b %h iok%b iaok%b expected 1 11112222 0 0", data_data_ok, data_rdata, inst_data_ok, inst_addr_ok); else passCount++;
        step();
        rdata = 32'h33334444;
        #1;
        checkCount++; if (inst_addr_ok !== 1'b1) $display("[TB] FAIL prio_inst_grant: got %b expected 1", inst_addr_ok); else passCount++;
        step();
        inst_req = 1'b0;
        #1;
        checkCount++; if (araddr !== 32'hBFC00004 || arvalid !== 1'b1) $display("[TB] FAIL prio_inst_ar: got %h v%b expected bfc00004 v1", araddr, arvalid); else passCount++;
        step();
        checkCount++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h33334444 || data_data_ok !== 1'b0) $display("[TB] FAIL prio_inst_data: got ok%b %h dok%b expected 1 33334444 0", inst_data_ok, inst_rdata, data_data_ok); else passCount++;
        step();
        rvalid  = 1'b0;
        arready = 1'b0;
    endtask

    task automatic test_byte_store();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h80000003;
        data_wdata = 32'hAB000000;
        awready    = 1'b1;
        wready     = 1'b1;
        #1;
        checkCount++; if (data_addr_ok !== 1'b1) $display("[TB] FAIL bst_grant: got %b expected 1", data_addr_ok); else passCount++;
        step();
        data_req = 1'b0;
        #1;
        checkCount++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || arvalid !== 1'b0) $display("[TB] FAIL bst_valids: got aw%b w%b ar%b expected 110", awvalid, wvalid, arvalid); else passCount++;
        checkCount++; if (awaddr !== 32'h80000003 || awsize !== 3'b000 || wstrb !== 4'b1000 || wdata !== 32'hAB000000) $display("[TB] FAIL bst_fields: got %h sz%b strb%b %h expected 80000003 000 1000 ab000000", awaddr, awsize, wstrb, wdata); else passCount++;
        step();
        awready = 1'b0;
        wready  = 1'b0;
        checkCount++; if (bready !== 1'b1 || data_data_ok !== 1'b0 || awvalid !== 1'b0) $display("[TB] FAIL bst_b: got br%b ok%b aw%b expected 1 0 0", bready, data_data_ok, awvalid); else passCount++;
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        #1;
        checkCount++; if (data_data_ok !== 1'b1 || bready !== 1'b0 || data_addr_ok !== 1'b0) $display("[TB] FAIL bst_done: got ok%b br%b aok%b expected 1 0 0", data_data_ok, bready, data_addr_ok); else passCount++;
        step();
        checkCount++; if (data_data_ok !== 1'b0) $display("[TB] FAIL bst_pulse: got %b expected 0", data_data_ok); else passCount++;
    endtask

    task automatic test_delayed_aw();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = 32'h80000102;
        data_wdata = 32'h12340000;
        wready     = 1'b1;
        awready    = 1'b0;
        #1;
        checkCount++; if (data_addr_ok !== 1'b1) $display("[TB] FAIL daw_grant: got %b expected 1", data_addr_ok); else passCount++;
        step();
        data_req = 1'b0;
        #1;
        checkCount++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1100 || awsize !== 3'b001) $display("[TB] FAIL daw_c1: got aw%b w%b strb%b sz%b expected 1 1 1100 001", awvalid, wvalid, wstrb, awsize); else passCount++;
        step();
        wready = 1'b0;
        #1;
        checkCount++; if (wvalid !== 1'b0 || awvalid !== 1'b1) $display("[TB] FAIL daw_c2: got w%b aw%b expected 0 1", wvalid, awvalid); else passCount++;
        step();
        checkCount++; if (awvalid !== 1'b1 || bready !== 1'b0) $display("[TB] FAIL daw_c3: got aw%b br%b expected 1 0", awvalid, bready); else passCount++;
        step();
        awready = 1'b1;
        #1;
        checkCount++; if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0) $display("[TB] FAIL daw_c4: got aw%b w%b br%b expected 1 0 0", awvalid, wvalid, bready); else passCount++;
        step();
        awready = 1'b0;
        #1;
        checkCount++; if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) $display("[TB] FAIL daw_c5: got br%b aw%b w%b expected 1 0 0", bready, awvalid, wvalid); else passCount++;
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        #1;
        checkCount++; if (data_data_ok !== 1'b1) $display("[TB] FAIL daw_done: got %b expected 1", data_data_ok); else passCount++;
        step();
    endtask

    task automatic test_ar_stall();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00010;
        inst_size = 2'd1;
        arready   = 1'b0;
        rvalid    = 1'b0;
        #1;
        checkCount++; if (inst_addr_ok !== 1'b1) $display("[TB] FAIL stall_grant: got %b expected 1", inst_addr_ok); else passCount++;
        step();
        inst_req  = 1'b0;
        inst_addr = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkCount++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00010 || arsize !== 3'b001 || inst_data_ok !== 1'b0) $display("[TB] FAIL stall_hold%0d: got v%b %h sz%b ok%b expected 1 bfc00010 001 0", i, arvalid, araddr, arsize, inst_data_ok); else passCount++;
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        #1;
        checkCount++; if (rready !== 1'b1 || inst_data_ok !== 1'b0 || arvalid !== 1'b0) $display("[TB] FAIL stall_r: got rr%b ok%b arv%b expected 1 0 0", rready, inst_data_ok, arvalid); else passCount++;
        rvalid = 1'b1;
        rdata  = 32'hCAFEF00D;
        #1;
        checkCount++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hCAFEF00D) $display("[TB] FAIL stall_data: got ok%b %h expected 1 cafef00d", inst_data_ok, inst_rdata); else passCount++;
        step();
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h80002000;
        arready   = 1'b1;
        rvalid    = 1'b0;
        #1;
        checkCount++; if (data_addr_ok !== 1'b1) $display("[TB] FAIL rmid_grant: got %b expected 1", data_addr_ok); else passCount++;
        step();
        data_req = 1'b0;
        step();
        checkCount++; if (rready !== 1'b1) $display("[TB] FAIL rmid_in_r: got %b expected 1", rready); else passCount++;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEADBEEF;
        #1;
        checkCount++; if (rready !== 1'b0 || data_data_ok !== 1'b0 || inst_data_ok !== 1'b0 || arvalid !== 1'b0) $display("[TB] FAIL rmid_idle: got rr%b dok%b iok%b arv%b expected 0000", rready, data_data_ok, inst_data_ok, arvalid); else passCount++;
        rvalid = 1'b0;
        step();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00020;
        inst_size = 2'd2;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h24080001;
        #1;
        checkCount++; if (inst_addr_ok !== 1'b1) $display("[TB] FAIL rmid_fresh_grant: got %b expected 1", inst_addr_ok); else passCount++;
        step();
        inst_req = 1'b0;
        step();
        checkCount++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h24080001) $display("[TB] FAIL rmid_fresh_data: got ok%b %h expected 1 24080001", inst_data_ok, inst_rdata); else passCount++;
        step();
        rvalid  = 1'b0;
        arready = 1'b0;
    endtask

    // Scenario sequence; all inputs are idle before the first edge.
    initial begin
        passCount  = 0;
        checkCount = 0;
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_size  = 2'd0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        arready    = 1'b0;
        rdata      = 32'h0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        test_reset();
        test_fetch();
        test_priority();
        test_byte_store();
        test_delayed_aw();
        test_ar_stall();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
